// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freezes on memory stalls, flushes on taken branches,
// inserts one-cycle load-use bubbles, and keeps saturating performance counters.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_br_taken,
    input  logic        imem_read,
    input  logic        imem_resp,
    input  logic        dmem_access,
    input  logic        dmem_resp,
    input  logic        cnt_clr,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        mem_waiting,
    output logic [31:0] stall_cycles,
    output logic [31:0] stall_events,
    output logic [31:0] lu_bubbles,
    output logic [31:0] br_flushes
);

    typedef enum logic [0:0] {StRun, StMemWait} state_e;

    state_e      state_q, state_d;
    logic        mem_stall, lu_hazard;
    logic        br_case, lu_case, event_case;
    logic [31:0] stall_cycles_q, stall_events_q, lu_bubbles_q, br_flushes_q;

    assign mem_stall = (imem_read & ~imem_resp) | (dmem_access & ~dmem_resp);
    assign lu_hazard = ex_valid & ex_is_load & (ex_rd != 5'd0) &
                       ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

    // Exiting a stall needs no special case: held EX/ID values are evaluated as in StRun.
    assign br_case    = ~rst & ~mem_stall & ex_br_taken;
    assign lu_case    = ~rst & ~mem_stall & ~ex_br_taken & lu_hazard;
    assign event_case = ~rst & mem_stall & (state_q == StRun);

    always_comb begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (rst) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (mem_stall) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
        end else if (ex_br_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (lu_hazard) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            flush_id_ex = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:     if (mem_stall)  state_d = StMemWait;
            StMemWait: if (!mem_stall) state_d = StRun;
            default:   state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            mem_waiting <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_waiting <= (state_d == StMemWait);
        end
    end

    // Saturating counters; cnt_clr wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cycles_q <= 32'd0;
            stall_events_q <= 32'd0;
            lu_bubbles_q   <= 32'd0;
            br_flushes_q   <= 32'd0;
        end else begin
            if (mem_stall && stall_cycles_q != 32'hFFFF_FFFF)
                stall_cycles_q <= stall_cycles_q + 32'd1;
            if (event_case && stall_events_q != 32'hFFFF_FFFF)
                stall_events_q <= stall_events_q + 32'd1;
            if (lu_case && lu_bubbles_q != 32'hFFFF_FFFF)
                lu_bubbles_q <= lu_bubbles_q + 32'd1;
            if (br_case && br_flushes_q != 32'hFFFF_FFFF)
                br_flushes_q <= br_flushes_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign stall_events = stall_events_q;
    assign lu_bubbles   = lu_bubbles_q;
    assign br_flushes   = br_flushes_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_valid, ex_is_load, ex_br_taken;
    logic        imem_read, imem_resp, dmem_access, dmem_resp, cnt_clr;
    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, flush_id_ex, mem_waiting;
    logic [31:0] stall_cycles, stall_events, lu_bubbles, br_flushes;
    logic [6:0]  ctl;

    int n_vec  = 0;
    int n_fail = 0;

    // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex}
    localparam logic [6:0] CtlNormal = 7'b11111_00;
    localparam logic [6:0] CtlStall  = 7'b00000_00;
    localparam logic [6:0] CtlBranch = 7'b11111_11;
    localparam logic [6:0] CtlLu     = 7'b00111_01;
    localparam logic [6:0] CtlRst    = 7'b00000_11;

    assign ctl = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                  flush_if_id, flush_id_ex};

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_br_taken(ex_br_taken),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_access(dmem_access), .dmem_resp(dmem_resp),
        .cnt_clr(cnt_clr),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .mem_waiting(mem_waiting),
        .stall_cycles(stall_cycles), .stall_events(stall_events),
        .lu_bubbles(lu_bubbles), .br_flushes(br_flushes)
    );

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; ex_br_taken = 1'b0;
        imem_read = 1'b0; imem_resp = 1'b0; dmem_access = 1'b0; dmem_resp = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        ex_br_taken = 1'b1;
        #1;
        n_vec++;
        if (ctl !== CtlRst) begin
            n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, CtlRst);
        end
        @(negedge clk);
        n_vec++;
        if ({mem_waiting, stall_cycles, stall_events, lu_bubbles, br_flushes} !== 129'd0) begin
            n_fail++;
            $display("FAIL reset_state: mw=%b sc=%0d se=%0d lu=%0d br=%0d want all 0",
                     mem_waiting, stall_cycles, stall_events, lu_bubbles, br_flushes);
        end
        rst = 1'b0;
        ex_br_taken = 1'b0;
        #1;
        n_vec++;
        if (ctl !== CtlNormal) begin
            n_fail++; $display("FAIL reset_release_ctl: got %b want %b", ctl, CtlNormal);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        #1;
        n_vec++;
        if (ctl !== CtlLu) begin
            n_fail++; $display("FAIL lu_bubble_ctl: got %b want %b", ctl, CtlLu);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        n_vec++;
        if (ctl !== CtlNormal) begin
            n_fail++; $display("FAIL lu_after_ctl: got %b want %b", ctl, CtlNormal);
        end
        n_vec++;
        if (lu_bubbles !== 32'd1) begin
            n_fail++; $display("FAIL lu_count: got %0d want 1", lu_bubbles);
        end
    endtask

    task automatic test_x0();
        do_reset();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0;
        id_rs1 = 5'd0; id_uses_rs1 = 1'b1; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
        #1;
        n_vec++;
        if (ctl !== CtlNormal) begin
            n_fail++; $display("FAIL x0_ctl: got %b want %b", ctl, CtlNormal);
        end
        // Matching rs1 but ID does not read it: no hazard either.
        @(negedge clk);
        ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        #1;
        n_vec++;
        if (ctl !== CtlNormal) begin
            n_fail++; $display("FAIL unused_src_ctl: got %b want %b", ctl, CtlNormal);
        end
        @(negedge clk);
        n_vec++;
        if (lu_bubbles !== 32'd0) begin
            n_fail++; $display("FAIL x0_count: got %0d want 0", lu_bubbles);
        end
    endtask

    task automatic test_mem_stall();
        do_reset();
        imem_read = 1'b1; imem_resp = 1'b0;
        #1;
        n_vec++;
        if (ctl !== CtlStall || mem_waiting !== 1'b0) begin
            n_fail++; $display("FAIL stall_enter: ctl=%b mw=%b want %b mw=0",
                               ctl, mem_waiting, CtlStall);
        end
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            n_vec++;
            if (ctl !== CtlStall || mem_waiting !== 1'b1 || stall_cycles !== 32'(i)) begin
                n_fail++; $display("FAIL stall_hold%0d: ctl=%b mw=%b sc=%0d want %b mw=1 sc=%0d",
                                   i, ctl, mem_waiting, stall_cycles, CtlStall, i);
            end
        end
        @(negedge clk);
        imem_resp = 1'b1;
        #1;
        n_vec++;
        if (ctl !== CtlNormal || mem_waiting !== 1'b1 || stall_cycles !== 32'd3) begin
            n_fail++; $display("FAIL stall_exit: ctl=%b mw=%b sc=%0d want %b mw=1 sc=3",
                               ctl, mem_waiting, stall_cycles, CtlNormal);
        end
        @(negedge clk);
        imem_read = 1'b0;
        n_vec++;
        if (mem_waiting !== 1'b0 || stall_cycles !== 32'd3 || stall_events !== 32'd1) begin
            n_fail++; $display("FAIL stall_after: mw=%b sc=%0d se=%0d want mw=0 sc=3 se=1",
                               mem_waiting, stall_cycles, stall_events);
        end
    endtask

    task automatic test_branch_stall();
        do_reset();
        dmem_access = 1'b1; dmem_resp = 1'b0; ex_br_taken = 1'b1;
        #1;
        n_vec++;
        if (ctl !== CtlStall) begin
            n_fail++; $display("FAIL br_stall0: got %b want %b", ctl, CtlStall);
        end
        @(negedge clk);
        n_vec++;
        if (ctl !== CtlStall || mem_waiting !== 1'b1) begin
            n_fail++; $display("FAIL br_stall1: ctl=%b mw=%b want %b mw=1",
                               ctl, mem_waiting, CtlStall);
        end
        @(negedge clk);
        dmem_resp = 1'b1;
        #1;
        n_vec++;
        if (ctl !== CtlBranch || br_flushes !== 32'd0) begin
            n_fail++; $display("FAIL br_exit: ctl=%b bf=%0d want %b bf=0",
                               ctl, br_flushes, CtlBranch);
        end
        @(negedge clk);
        ex_br_taken = 1'b0; dmem_access = 1'b0;
        #1;
        n_vec++;
        if (ctl !== CtlNormal || br_flushes !== 32'd1 || stall_cycles !== 32'd2 ||
            stall_events !== 32'd1) begin
            n_fail++; $display("FAIL br_after: ctl=%b bf=%0d sc=%0d se=%0d want %b bf=1 sc=2 se=1",
                               ctl, br_flushes, stall_cycles, stall_events, CtlNormal);
        end
    endtask

    task automatic test_branch_lu();
        do_reset();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
        ex_br_taken = 1'b1;
        #1;
        n_vec++;
        if (ctl !== CtlBranch) begin
            n_fail++; $display("FAIL br_lu_ctl: got %b want %b", ctl, CtlBranch);
        end
        @(negedge clk);
        clear_inputs();
        n_vec++;
        if (lu_bubbles !== 32'd0 || br_flushes !== 32'd1) begin
            n_fail++; $display("FAIL br_lu_count: lu=%0d bf=%0d want lu=0 bf=1",
                               lu_bubbles, br_flushes);
        end
    endtask

    task automatic test_counters();
        do_reset();
        dmem_access = 1'b1; dmem_resp = 1'b0;
        #2;
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles_q;
        @(negedge clk);
        n_vec++;
        if (stall_cycles !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL sat_reach: got %h want ffffffff", stall_cycles);
        end
        @(negedge clk);
        n_vec++;
        if (stall_cycles !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL sat_hold: got %h want ffffffff", stall_cycles);
        end
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        n_vec++;
        if (stall_cycles !== 32'd0 || stall_events !== 32'd0 || mem_waiting !== 1'b1) begin
            n_fail++; $display("FAIL cnt_clr: sc=%0d se=%0d mw=%b want sc=0 se=0 mw=1",
                               stall_cycles, stall_events, mem_waiting);
        end
        @(negedge clk);
        n_vec++;
        if (stall_cycles !== 32'd1 || stall_events !== 32'd0) begin
            n_fail++; $display("FAIL clr_resume: sc=%0d se=%0d want sc=1 se=0",
                               stall_cycles, stall_events);
        end
        dmem_access = 1'b0;
    endtask

    task automatic test_rst_mid_stall();
        do_reset();
        imem_read = 1'b1; imem_resp = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if (ctl !== CtlRst || mem_waiting !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_ctl: ctl=%b mw=%b want %b mw=1",
                               ctl, mem_waiting, CtlRst);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (mem_waiting !== 1'b0 || stall_cycles !== 32'd0 || stall_events !== 32'd0 ||
            ctl !== CtlStall) begin
            n_fail++; $display("FAIL rst_mid_after: mw=%b sc=%0d se=%0d ctl=%b want 0 0 0 %b",
                               mem_waiting, stall_cycles, stall_events, ctl, CtlStall);
        end
        @(negedge clk);
        n_vec++;
        if (stall_events !== 32'd1 || mem_waiting !== 1'b1 || stall_cycles !== 32'd1) begin
            n_fail++; $display("FAIL rst_mid_restart: se=%0d mw=%b sc=%0d want se=1 mw=1 sc=1",
                               stall_events, mem_waiting, stall_cycles);
        end
        imem_read = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_x0();
        test_mem_stall();
        test_branch_stall();
        test_branch_lu();
        test_counters();
        test_rst_mid_stall();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports clk (in, 1, clock) then rst (in, 1, reset); one clock; reset is synchronous and active-high.
REQ-002 SHALL have id_rs1, id_rs2 (in, 5 each): source registers of the instruction in ID.
REQ-003 SHALL have id_uses_rs1, id_uses_rs2 (in, 1 each): ID instruction actually reads that source.
REQ-004 SHALL have ex_valid (in, 1), ex_is_load (in, 1), ex_rd (in, 5): the instruction held in ID/EX.
REQ-005 SHALL have ex_br_taken (in, 1): EX resolved a taken branch or jump; PC target mux is external.
REQ-006 SHALL have imem_read, imem_resp, dmem_access, dmem_resp (in, 1 each): fetch and MEM-stage memory request and ack.
REQ-007 SHALL have cnt_clr (in, 1): synchronous clear of the performance counters.
REQ-008 SHALL have load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb (out, 1 each): register enables.
REQ-009 SHALL have flush_if_id, flush_id_ex (out, 1 each): load a bubble (NOP, invalid rvfi) into that buffer.
REQ-010 SHALL have mem_waiting (out, 1): registered, high while the FSM is in MEM_WAIT.
REQ-011 SHALL have stall_cycles, stall_events, lu_bubbles, br_flushes (out, 32 each): performance counters.

Function
REQ-012 mem_stall = (imem_read & ~imem_resp) | (dmem_access & ~dmem_resp).
REQ-013 lu_hazard = ex_valid & ex_is_load & ex_rd != 0 & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)); x0 never hazards.
REQ-014 Enable and flush outputs SHALL be combinational from the current inputs and rst, with zero-cycle latency.
REQ-015 The outputs SHALL follow one fixed priority: rst > mem_stall > ex_br_taken > lu_hazard > normal.
REQ-016 mem_stall: all five load_* = 0 and both flush_* = 0, so the whole pipeline freezes and the EX inputs stay stable.
REQ-017 ex_br_taken without mem_stall: all load_* = 1, flush_if_id = 1, flush_id_ex = 1.
REQ-018 A branch that coincides with lu_hazard SHALL flush, not bubble; lu_bubbles SHALL NOT increment.
REQ-019 lu_hazard alone: load_pc = 0, load_if_id = 0, load_id_ex = 1, flush_id_ex = 1, load_ex_mem = 1, load_mem_wb = 1, flush_if_id = 0.
REQ-020 A lu_hazard bubble is exactly one cycle: the next cycle ID/EX holds a bubble (ex_valid = 0), so lu_hazard drops.
REQ-021 Normal: all load_* = 1, both flush_* = 0.
REQ-022 FSM states SHALL be RUN and MEM_WAIT.
REQ-023 FSM transitions: RUN->MEM_WAIT when mem_stall; MEM_WAIT->RUN when ~mem_stall; otherwise hold.
REQ-024 The cycle that exits a stall SHALL evaluate branch and load-use from the held EX/ID values exactly as in RUN; a held ex_br_taken yields one flush on exit.
REQ-025 stall_cycles SHALL +1 on every cycle with mem_stall.
REQ-026 stall_events SHALL +1 on each RUN->MEM_WAIT transition.
REQ-027 lu_bubbles SHALL +1 on each cycle where REQ-019 applies.
REQ-028 br_flushes SHALL +1 on each cycle where REQ-017 applies.
REQ-029 All counters SHALL saturate at 32'hFFFF_FFFF and never wrap.
REQ-030 cnt_clr SHALL zero all four counters next edge, overriding a same-cycle increment; the FSM is unaffected.

Reset
REQ-031 While rst = 1: all load_* = 0, flush_if_id = 1, flush_id_ex = 1.
REQ-032 At the clk edge with rst = 1: state = RUN, mem_waiting = 0, all counters = 0.
REQ-033 rst asserted mid-stall SHALL abandon MEM_WAIT without counting, and the next cycle SHALL start in RUN.

Verification
REQ-034 Load-use: ex_valid = 1, ex_is_load = 1, ex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1 -> load_pc = 0, load_if_id = 0, flush_id_ex = 1; then ex_valid = 0 -> all load_* = 1, lu_bubbles = 1.
REQ-035 x0: as in REQ-034 but ex_rd = 0, id_rs1 = 0 -> no bubble, all load_* = 1.
REQ-036 Memory stall: imem_read = 1, imem_resp = 0 for 3 cycles, then imem_resp = 1 -> 3 cycles of all-zero enables, mem_waiting high for 3 cycles, stall_cycles = 3, stall_events = 1.
REQ-037 Branch during stall: dmem stall with ex_br_taken = 1 for 2 cycles -> no flush while stalled; one cycle of flush_if_id = flush_id_ex = 1 on exit; br_flushes = 1.
REQ-038 Branch plus load-use in the same cycle -> flush_if_id = flush_id_ex = 1, load_pc = 1, lu_bubbles unchanged.
REQ-039 Counters: preload stall_cycles to 32'hFFFF_FFFE via a forced stall, hold the stall -> stays at 32'hFFFF_FFFF; cnt_clr = 1 during the stall -> 0 next cycle.
